// File: rtl/spi_atten_sequencer.sv
// spi_atten_sequencer: queues attenuator commands and feeds them one frame at a
// time to a downstream SPI serializer, watching the serializer CS for completion.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for a queued command while the serializer CS is low
// LOAD    | ser_data valid, ser_ld held high for LD_CYCLES cycles
// WAIT_HI | waiting for the serializer to raise CS (bounded by TIMEOUT_CYCLES)
// WAIT_LO | frame shifted, waiting for CS to fall to signal completion
// GAP     | one idle cycle so ser_ld stays low between frames
module spi_atten_sequencer #(
  parameter int         FIFO_DEPTH     = 4,
  parameter int         LD_CYCLES      = 2,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] CMD_BYTE       = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [7:0]                    s_addr,
  input  logic [7:0]                    s_atten,
  output logic [31:0]                   ser_data,
  output logic                          ser_ld,
  input  logic                          ser_cs,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_count;
  logic             r_run;
  state_t           r_state;
  logic             r_ld;
  logic [31:0]      r_data;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_ld_cnt;
  logic [TMR_W-1:0] r_tmr;

  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [15:0]      w_head;

  // s_ready comes from registered state only; r_run keeps it low through reset
  assign w_ready = r_run && (r_count != LVL_W'(FIFO_DEPTH));
  assign w_push  = s_valid && w_ready;
  assign w_pop   = (r_state == ST_IDLE) && (r_count != '0) && !ser_cs;
  assign w_head  = r_mem[r_rptr];

  assign s_ready     = w_ready;
  assign ser_data    = r_data;
  assign ser_ld      = r_ld;
  assign done_pulse  = r_done;
  assign timeout_err = r_err;
  assign fifo_level  = r_count;
  assign busy        = (r_state != ST_IDLE) || (r_count != '0);

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {s_addr, s_atten};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // frame sequencing FSM with registered strobes and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ld     <= 1'b0;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ld_cnt <= '0;
      r_tmr    <= '0;
    end else begin
      r_done <= 1'b0;
      if (err_clr) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_data   <= {8'h00, CMD_BYTE, w_head};
            r_ld     <= 1'b1;
            r_ld_cnt <= 8'(LD_CYCLES - 1);
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_ld_cnt == '0) begin
            r_ld    <= 1'b0;
            r_tmr   <= TMR_W'(TIMEOUT_CYCLES - 1);
            r_state <= ST_WAIT_HI;
          end else begin
            r_ld_cnt <= r_ld_cnt - 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (ser_cs) begin
            r_state <= ST_WAIT_LO;
          end else if (r_tmr == '0) begin
            // a new timeout overrides a coincident clear
            r_err   <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!ser_cs) begin
            r_done  <= 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_ld    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_atten_sequencer.sv
// Bench for spi_atten_sequencer: a serializer model answers each load with a
// CS pulse, and a scoreboard checks every loaded word against the pushed order.
module tb_spi_atten_sequencer;

  localparam logic [7:0] CMD = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_addr;
  logic [7:0]  s_atten;
  logic [31:0] ser_data;
  logic        ser_ld;
  wire         ser_cs;
  logic        busy;
  logic        done_pulse;
  logic        timeout_err;
  logic [2:0]  fifo_level;
  logic        err_clr;

  logic        cs_man;
  logic        model_en;
  logic        m_cs;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  int          ld_rises = 0;
  int          ld_len   = 0;
  logic        ignore_len = 1'b0;
  logic [31:0] exp_q [$];

  assign ser_cs = model_en ? m_cs : cs_man;

  always #5 clk = ~clk;

  spi_atten_sequencer #(
    .FIFO_DEPTH    (4),
    .LD_CYCLES     (2),
    .TIMEOUT_CYCLES(16),
    .CMD_BYTE      (CMD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_addr     (s_addr),
    .s_atten    (s_atten),
    .ser_data   (ser_data),
    .ser_ld     (ser_ld),
    .ser_cs     (ser_cs),
    .busy       (busy),
    .done_pulse (done_pulse),
    .timeout_err(timeout_err),
    .fifo_level (fifo_level),
    .err_clr    (err_clr)
  );

  // serializer model: after ser_ld falls, CS rises 2 cycles later for 4 cycles
  initial begin
    int   m_cnt;
    logic m_prev;
    m_cs = 1'b0; m_cnt = 0; m_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        m_cnt = 0;
        m_cs  = 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt++;
        m_cs = (m_cnt >= 3 && m_cnt <= 6);
        if (m_cnt >= 8) m_cnt = 0;
      end else if (m_prev && !ser_ld) begin
        m_cnt = 1;
      end
      m_prev = ser_ld;
    end
  end

  // output monitor: scoreboard pop on each load, load width, data hold, done count
  initial begin
    logic        prev_ld;
    logic [31:0] held;
    logic [31:0] w;
    prev_ld = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (ser_ld && !prev_ld) begin
        ld_rises++;
        ld_len = 1;
        held   = ser_data;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_frame: got %h, no frame expected", ser_data);
        end else begin
          w = exp_q.pop_front();
          if (ser_data !== w) $display("FAIL sb_word: got %h want %h", ser_data, w);
          else n_pass++;
        end
      end else if (ser_ld) begin
        ld_len++;
        n_checks++;
        if (ser_data !== held) $display("FAIL data_hold: got %h want %h", ser_data, held);
        else n_pass++;
      end else if (prev_ld && !ignore_len) begin
        n_checks++;
        if (ld_len !== 2) $display("FAIL ld_width: got %0d want 2", ld_len);
        else n_pass++;
      end
      if (done_pulse) done_cnt++;
      prev_ld = ser_ld;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] t);
    int n;
    n = 0;
    s_addr = a; s_atten = t; s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!s_ready) begin
      $display("FAIL push_accept: s_ready got %b want 1 within 200 cycles", s_ready);
      s_valid = 1'b0;
      return;
    end
    n_pass++;
    @(posedge clk);
    exp_q.push_back({8'h00, CMD, a, t});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done_cnt != target || busy)
      $display("FAIL wait_done: done count got %0d want %0d, busy %b", done_cnt, target, busy);
    else n_pass++;
  endtask

  task automatic wait_ld_fall();
    int n;
    n = 0;
    while (!ser_ld && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (ser_ld && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100) $display("FAIL wait_ld_fall: no load strobe within 100 cycles");
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_atten = '0; err_clr = 1'b0;
    cs_man = 1'b0; model_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 7;
    if (ser_ld !== 1'b0) $display("FAIL rst_ld: got %b want 0", ser_ld); else n_pass++;
    if (ser_data !== 32'h0) $display("FAIL rst_data: got %h want 0", ser_data); else n_pass++;
    if (s_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", s_ready); else n_pass++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    if (done_pulse !== 1'b0) $display("FAIL rst_done: got %b want 0", done_pulse); else n_pass++;
    if (timeout_err !== 1'b0) $display("FAIL rst_err: got %b want 0", timeout_err); else n_pass++;
    if (fifo_level !== 3'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL ready_after_rst: got %b want 1", s_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    int d0;
    d0 = done_cnt;
    model_en = 1'b1;
    push(8'h03, 8'h2A);
    n_checks += 3;
    if (ser_ld !== 1'b0) $display("FAIL single_ld_early: got %b want 0", ser_ld); else n_pass++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    if (fifo_level !== 3'd1) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
    @(negedge clk);
    n_checks += 3;
    if (ser_ld !== 1'b1) $display("FAIL single_ld_latency: got %b want 1", ser_ld); else n_pass++;
    if (ser_data !== 32'h0000032A) $display("FAIL single_word: got %h want 0000032a", ser_data); else n_pass++;
    if (fifo_level !== 3'd0) $display("FAIL single_popped: got %0d want 0", fifo_level); else n_pass++;
    wait_done(d0 + 1);
    repeat (5) @(negedge clk);
    n_checks += 2;
    if (done_cnt !== d0 + 1) $display("FAIL single_done_once: got %0d want %0d", done_cnt, d0 + 1); else n_pass++;
    if (timeout_err !== 1'b0) $display("FAIL single_no_err: got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_fill();
    int d0;
    d0 = done_cnt;
    model_en = 1'b0;
    cs_man = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 8'hA0 + 8'(i));
    n_checks += 3;
    if (fifo_level !== 3'd4) $display("FAIL fill_level: got %0d want 4", fifo_level); else n_pass++;
    if (s_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", s_ready); else n_pass++;
    if (ser_ld !== 1'b0) $display("FAIL fill_cs_block: got %b want 0", ser_ld); else n_pass++;
    fork
      push(8'h14, 8'hA4);
      begin
        repeat (3) @(negedge clk);
        n_checks += 2;
        if (s_ready !== 1'b0) $display("FAIL fill_held: got %b want 0", s_ready); else n_pass++;
        if (fifo_level !== 3'd4) $display("FAIL fill_held_level: got %0d want 4", fifo_level); else n_pass++;
        cs_man = 1'b0;
        model_en = 1'b1;
      end
    join
    wait_done(d0 + 5);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL fill_all_emitted: %0d frames outstanding, want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int d0;
    int n;
    d0 = done_cnt;
    model_en = 1'b0;
    cs_man = 1'b0;
    push(8'h11, 8'h22);
    wait_ld_fall();
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks += 2;
    if (n !== 16) $display("FAIL timeout_delay: got %0d cycles want 16", n); else n_pass++;
    if (done_cnt !== d0) $display("FAIL timeout_no_done: got %0d want %0d", done_cnt, d0); else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL err_clear: got %b want 0", timeout_err); else n_pass++;
    model_en = 1'b1;
    push(8'h33, 8'h44);
    wait_done(d0 + 1);
  endtask

  task automatic test_err_clear_collide();
    model_en = 1'b0;
    cs_man = 1'b0;
    push(8'h77, 8'h88);
    wait_ld_fall();
    repeat (15) @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL collide_pre: got %b want 0", timeout_err); else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL collide_set_wins: got %b want 1", timeout_err); else n_pass++;
    err_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", timeout_err); else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL collide_clear: got %b want 0", timeout_err); else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cs_start();
    int d0;
    d0 = done_cnt;
    model_en = 1'b0;
    cs_man = 1'b1;
    push(8'h55, 8'h66);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (ser_ld !== 1'b0) $display("FAIL cs_block_%0d: got %b want 0", i, ser_ld); else n_pass++;
    end
    n_checks++;
    if (fifo_level !== 3'd1) $display("FAIL cs_block_level: got %0d want 1", fifo_level); else n_pass++;
    cs_man = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ser_ld !== 1'b1) $display("FAIL cs_release_ld: got %b want 1", ser_ld); else n_pass++;
    model_en = 1'b1;
    wait_done(d0 + 1);
  endtask

  task automatic test_reset_mid();
    int d0;
    int r0;
    model_en = 1'b0;
    cs_man = 1'b1;
    ignore_len = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 8'h50 + 8'(i));
    cs_man = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (ser_ld !== 1'b1) $display("FAIL mid_in_load: got %b want 1", ser_ld); else n_pass++;
    if (fifo_level !== 3'd3) $display("FAIL mid_queued: got %0d want 3", fifo_level); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks += 5;
    if (ser_ld !== 1'b0) $display("FAIL mid_ld_drop: got %b want 0", ser_ld); else n_pass++;
    if (fifo_level !== 3'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else n_pass++;
    if (s_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", s_ready); else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    if (ser_data !== 32'h0) $display("FAIL mid_data: got %h want 0", ser_data); else n_pass++;
    exp_q.delete();
    d0 = done_cnt;
    r0 = ld_rises;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks += 4;
    if (ld_rises !== r0) $display("FAIL mid_no_frames: got %0d loads want %0d", ld_rises, r0); else n_pass++;
    if (done_cnt !== d0) $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_idle: got %b want 0", busy); else n_pass++;
    if (s_ready !== 1'b1) $display("FAIL mid_ready_back: got %b want 1", s_ready); else n_pass++;
    ignore_len = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_err_clear_collide();
    test_cs_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_atten_sequencer.md
SPI_ATTEN_SEQUENCER -- requirements
Module: spi_atten_sequencer

Interface
REQ-001 The block SHALL have the parameter FIFO_DEPTH, default 4, which sets the number of queued attenuator commands (power of two, 2..16).
REQ-002 The block SHALL have the parameter LD_CYCLES, default 2, which sets the number of clk cycles ser_ld is held high per command (1..255).
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 4096, which sets the maximum number of clk cycles to wait for ser_cs to rise after ser_ld falls.
REQ-004 The block SHALL have the parameter CMD_BYTE, default 8'h00, which is the fixed byte placed in word bits [23:16].
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the ports s_valid (input, 1), s_ready (output, 1), s_addr (input, 8) and s_atten (input, 8), which form the command write handshake.
REQ-008 The block SHALL have the port ser_data, output, 32 bits: the word presented to the downstream serializer's Data_Register.
REQ-009 The block SHALL have the port ser_ld, output, 1 bit: the load strobe to the serializer.
REQ-010 The block SHALL have the port ser_cs, input, 1 bit: the serializer CS output, which is high for the completion window after a frame is shifted.
REQ-011 The block SHALL have the outputs busy (1), done_pulse (1), timeout_err (1, sticky) and fifo_level ($clog2(FIFO_DEPTH)+1 bits), and the input err_clr (1).

Function
REQ-012 The block SHALL accept a command on any cycle where s_valid && s_ready; s_ready SHALL equal (fifo_level != FIFO_DEPTH) and be computed from registered count only, with no combinational path from s_valid.
REQ-013 The FIFO SHALL be circular with wrap-around pointers; a push and a pop in the same cycle SHALL leave fifo_level unchanged; a push while full SHALL be impossible by REQ-012.
REQ-014 The word format SHALL be: ser_data[7:0]=atten, [15:8]=addr, [23:16]=CMD_BYTE, [31:24]=0, so that 24 bits are shifted LSB-first.
REQ-015 The state machine SHALL have the states IDLE, LOAD, WAIT_HI, WAIT_LO and GAP.
REQ-016 In IDLE, when the FIFO is non-empty and ser_cs==0, the block SHALL pop the head entry, register the word into ser_data, and enter LOAD on the next cycle.
REQ-017 In LOAD, ser_ld SHALL be 1 for exactly LD_CYCLES consecutive cycles, then 0, and the block SHALL enter WAIT_HI.
REQ-018 In WAIT_HI, the block SHALL count cycles; on ser_cs==1 it SHALL enter WAIT_LO; if the count reaches TIMEOUT_CYCLES with ser_cs still 0, it SHALL set timeout_err, discard the command and enter GAP.
REQ-019 In WAIT_LO, on ser_cs==0 the block SHALL assert done_pulse for exactly one cycle and enter GAP.
REQ-020 GAP SHALL last 1 cycle and then return to IDLE, guaranteeing that ser_ld is low for at least 2 cycles between frames.
REQ-021 ser_data SHALL be held stable from LOAD until the next pop; it SHALL NOT change while ser_ld==1 or in WAIT_HI/WAIT_LO.
REQ-022 busy SHALL be 1 whenever the state is not IDLE or fifo_level!=0.
REQ-023 timeout_err SHALL clear on err_clr==1; if a set and err_clr occur in the same cycle, the set SHALL win.
REQ-024 ser_cs==1 while the block is in IDLE SHALL block the start of a new frame until ser_cs falls.
REQ-025 Commands SHALL be issued in strict FIFO order, one frame at a time; latency from a push into an empty idle block to ser_ld rising SHALL be 2 cycles.

Reset
REQ-026 While rst==1 the outputs SHALL be: ser_ld=0, ser_data=0, s_ready=0, busy=0, done_pulse=0, timeout_err=0, fifo_level=0, state=IDLE, with the FIFO emptied.
REQ-027 On the first clk edge after rst falls, s_ready SHALL be 1.
REQ-028 A reset mid-frame, including while ser_ld is high, SHALL drop ser_ld immediately and discard all queued commands.

Verification
REQ-029 Scenario (single write): push addr=8'h03, atten=8'h2A with a serializer model (LD_CYCLES=2) -> ser_data=32'h00032A, ser_ld high for 2 cycles, done_pulse once after ser_cs falls.
REQ-030 Scenario (fill FIFO): push 5 commands back-to-back -> s_ready=0 after the 4th push while the first frame has not yet been popped, the 5th is held until s_ready returns, and all 5 frames are emitted in order.
REQ-031 Scenario (timeout): ser_cs tied to 0, TIMEOUT_CYCLES=16 -> timeout_err=1 16 cycles after ser_ld falls, no done_pulse, and the next command proceeds.
REQ-032 Scenario (error clear): pulse err_clr one cycle after timeout_err sets -> timeout_err returns to 0; err_clr coinciding with a new timeout -> timeout_err stays 1.
REQ-033 Scenario (reset mid-frame): assert rst during LOAD with 3 entries queued -> ser_ld=0 the same cycle, fifo_level=0, and no done_pulse after release.
REQ-034 Scenario (CS held at start): ser_cs=1 before the first push -> ser_ld stays 0 until ser_cs falls, then rises 1 cycle later.
